page_chain_allocator: RTL

//  Consumer of the free-page FIFO: hands one free page per granted request to the packet writer.

---
 rtl/page_pkg.sv | 22 ++
 rtl/page_link_ram.sv | 33 +++
 rtl/page_chain_allocator.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/page_pkg.sv
// Shared constants and types for the page chain allocator and its link RAM.
package page_pkg;

  localparam int PAGE_NUM = 2048;
  localparam int PAGE_AW  = $clog2(PAGE_NUM);
  localparam int LEN_W    = $clog2(PAGE_NUM) + 1;

  typedef logic [PAGE_AW-1:0] page_t;
  typedef logic [LEN_W-1:0]   len_t;

  typedef struct packed {
    page_t head;
    page_t tail;
    len_t  len;
  } pkt_desc_t;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/page_link_ram.sv
// Next-page link storage: one write port, one registered read port with write-first bypass.
module page_link_ram
  import page_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [PAGE_AW-1:0] waddr_i,
  input  logic [PAGE_AW-1:0] wdata_i,
  input  logic               re_i,
  input  logic [PAGE_AW-1:0] raddr_i,
  output logic [PAGE_AW-1:0] rdata_o
);

  page_t mem_q [PAGE_NUM];
  page_t rdata_q;

  // Array kept reset-free so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/page_chain_allocator.sv
// Grants free pages, chains them per packet in the link RAM and emits packet descriptors.
// Optional PAGE_ERR_EN adds sticky err_flags and saturates free_cnt on over-release.
module page_chain_allocator
  import page_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alloc_req,
  input  logic               alloc_first,
  input  logic               alloc_last,
  output logic               alloc_ready,
  output logic [PAGE_AW-1:0] alloc_page,
  output logic               fifo_pop,
  input  logic [PAGE_AW-1:0] fifo_head,
  output logic               fifo_push,
  output logic [PAGE_AW-1:0] fifo_tail,
  input  logic               rel_valid,
  input  logic [PAGE_AW-1:0] rel_page,
  output logic               desc_valid,
  input  logic               desc_ready,
  output logic [PAGE_AW-1:0] desc_head,
  output logic [PAGE_AW-1:0] desc_tail,
  output logic [LEN_W-1:0]   desc_len,
  input  logic               link_rd_en,
  input  logic [PAGE_AW-1:0] link_rd_addr,
  output logic [PAGE_AW-1:0] link_rd_data,
  output logic [LEN_W-1:0]   free_cnt
`ifdef PAGE_ERR_EN
  ,
  output logic [2:0]         err_flags
`endif
);

  alloc_state_e state_q, state_d;
  page_t        head_q, head_d;
  page_t        prev_q, prev_d;
  len_t         len_q, len_d;
  len_t         free_q, free_d;
  pkt_desc_t    desc_q, desc_d;
  logic         desc_vld_q, desc_vld_d;
  logic         grant;
  logic         link_we;
  logic         free_full;

  assign free_full = (free_q == len_t'(PAGE_NUM));

  // Held descriptor blocks grants so a new load can never overwrite it.
  assign alloc_ready = rst_n & (free_q != '0) & ~(desc_vld_q & ~desc_ready);
  assign grant       = alloc_req & alloc_ready;
  assign alloc_page  = fifo_head;
  assign fifo_pop    = grant;
  assign fifo_push   = rst_n & rel_valid;
  assign fifo_tail   = rel_page;

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    prev_d     = prev_q;
    len_d      = len_q;
    desc_d     = desc_q;
    desc_vld_d = desc_vld_q;
    link_we    = 1'b0;

    if (desc_vld_q && desc_ready) desc_vld_d = 1'b0;

    if (grant) begin
      if (state_q == OPEN) link_we = 1'b1;
      if (state_q == OPEN && !alloc_first) begin
        prev_d = fifo_head;
        len_d  = len_q + len_t'(1);
        if (alloc_last) begin
          desc_d     = '{head: head_q, tail: fifo_head, len: len_q + len_t'(1)};
          desc_vld_d = 1'b1;
          state_d    = IDLE;
        end
      end else begin
        // Fresh packet: explicit first, a missing first in IDLE, or an abandoned chain.
        head_d = fifo_head;
        prev_d = fifo_head;
        len_d  = len_t'(1);
        if (alloc_last) begin
          desc_d     = '{head: fifo_head, tail: fifo_head, len: len_t'(1)};
          desc_vld_d = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d    = OPEN;
        end
      end
    end
  end

  always_comb begin
    free_d = free_q;
    if (grant && !fifo_push) begin
      free_d = free_q - len_t'(1);
    end else if (!grant && fifo_push) begin
`ifdef PAGE_ERR_EN
      free_d = free_full ? free_q : free_q + len_t'(1);
`else
      free_d = free_q + len_t'(1);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      head_q     <= '0;
      prev_q     <= '0;
      len_q      <= '0;
      free_q     <= len_t'(PAGE_NUM);
      desc_q     <= '0;
      desc_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      prev_q     <= prev_d;
      len_q      <= len_d;
      free_q     <= free_d;
      desc_q     <= desc_d;
      desc_vld_q <= desc_vld_d;
    end
  end

`ifdef PAGE_ERR_EN
  logic [2:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      if (rel_valid && free_full) err_q[0] <= 1'b1;
      if (alloc_req && (free_q == '0)) err_q[1] <= 1'b1;
      if (grant && (((state_q == IDLE) && !alloc_first) || ((state_q == OPEN) && alloc_first)))
        err_q[2] <= 1'b1;
    end
  end

  assign err_flags = err_q;
`else
  logic unused_full;
  assign unused_full = free_full;
`endif

  assign desc_valid = desc_vld_q;
  assign desc_head  = desc_q.head;
  assign desc_tail  = desc_q.tail;
  assign desc_len   = desc_q.len;
  assign free_cnt   = free_q;

  page_link_ram u_link_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (link_we),
    .waddr_i (prev_q),
    .wdata_i (fifo_head),
    .re_i    (link_rd_en),
    .raddr_i (link_rd_addr),
    .rdata_o (link_rd_data)
  );

endmodule
